// File: rtl/vc_fifo_pkg.sv
// vc_fifo_pkg: shared helpers and types for the virtual-channel FIFO bank.
// Provides clog2_min1 (channel-index width, never below 1 bit), OCC_EXTRA
// (extra occupancy bit so a count can hold the full DEPTH value), and the
// per-channel status struct.
package vc_fifo_pkg;

    localparam int OCC_EXTRA = 1;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } vc_status_t;

    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/vc_fifo_channel.sv
// vc_fifo_channel: one circular FIFO with pointers, count, status flags and sticky errors.
// Ports:
//   clk, reset (async, active-high), init (active-low sync flush)
//   wr_en / rd_en   : requests already decoded for this channel
//   data_in         : write payload
//   umbral_lo/hi    : almost-empty threshold / almost-full margin
//   head            : word at the read pointer (combinational)
//   status          : full / empty / almost_full / almost_empty
//   rd_ok           : read accepted this cycle
//   err_ovf/err_udf : sticky overflow / underflow
//   cnt             : live occupancy (only when VCF_OCC_EN is defined)
module vc_fifo_channel
    import vc_fifo_pkg::*;
#(
    parameter int DATA_W = 6,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = ADDR_W + OCC_EXTRA
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CNT_W-1:0]  umbral_lo,
    input  logic [CNT_W-1:0]  umbral_hi,
    output logic [DATA_W-1:0] head,
    output vc_status_t        status,
    output logic              rd_ok,
    output logic              err_ovf,
    output logic              err_udf
`ifdef VCF_OCC_EN
    ,
    output logic [CNT_W-1:0]  cnt
`endif
);

    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2 ** ADDR_W);

    logic [DATA_W-1:0] mem [2 ** ADDR_W];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, hi_lim;
    logic              ovf_q, ovf_d, udf_q, udf_d, wr_ok;
    vc_status_t        st;

    always_comb begin
        // A margin larger than the FIFO saturates the almost-full limit at 0.
        hi_lim          = (umbral_hi > DEPTH) ? '0 : DEPTH - umbral_hi;
        st.full         = cnt_q == DEPTH;
        st.empty        = cnt_q == '0;
        st.almost_empty = cnt_q <= umbral_lo;
        st.almost_full  = (cnt_q >= hi_lim) && !st.full;
        // Flags are start-of-cycle, so a same-cycle read never frees room for a write.
        wr_ok           = wr_en && !st.full && init;
        rd_ok           = rd_en && !st.empty && init;
        wr_ptr_d        = wr_ptr_q + ADDR_W'(wr_ok);
        rd_ptr_d        = rd_ptr_q + ADDR_W'(rd_ok);
        cnt_d           = cnt_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
        ovf_d           = ovf_q | (wr_en & st.full);
        udf_d           = udf_q | (rd_en & st.empty);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || !init) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_q] <= data_in;
    end

    assign head    = mem[rd_ptr_q];
    assign status  = st;
    assign err_ovf = ovf_q;
    assign err_udf = udf_q;
`ifdef VCF_OCC_EN
    assign cnt     = cnt_q;
`endif

endmodule

// File: rtl/vc_fifo_bank.sv
// vc_fifo_bank: NUM_VC independent FIFOs behind one shared write port and one shared read port.
// Ports:
//   clk, reset (async, active-high), init (active-low sync flush)
//   wr_en/wr_vc/data_in : write request, target channel, payload
//   rd_en/rd_vc         : read request, source channel
//   umbral_lo/umbral_hi : per-channel thresholds, channel i at [i*CNT_W +: CNT_W]
//   data_out/valid_out  : registered read data, valid for one cycle per accepted read
//   head_data           : head-of-queue word per channel
//   full/empty/almost_full/almost_empty/err_ovf/err_udf : per-channel status bits
//   occ                 : per-channel occupancy, present only when VCF_OCC_EN is defined
module vc_fifo_bank
    import vc_fifo_pkg::*;
#(
    parameter int DATA_W = 6,
    parameter int ADDR_W = 4,
    parameter int NUM_VC = 2,
    parameter int VC_W   = clog2_min1(NUM_VC),
    parameter int CNT_W  = ADDR_W + OCC_EXTRA
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic                    wr_en,
    input  logic [VC_W-1:0]         wr_vc,
    input  logic [DATA_W-1:0]       data_in,
    input  logic                    rd_en,
    input  logic [VC_W-1:0]         rd_vc,
    input  logic [NUM_VC*CNT_W-1:0] umbral_lo,
    input  logic [NUM_VC*CNT_W-1:0] umbral_hi,
    output logic [DATA_W-1:0]       data_out,
    output logic                    valid_out,
    output logic [NUM_VC*DATA_W-1:0] head_data,
    output logic [NUM_VC-1:0]       full,
    output logic [NUM_VC-1:0]       empty,
    output logic [NUM_VC-1:0]       almost_full,
    output logic [NUM_VC-1:0]       almost_empty,
    output logic [NUM_VC-1:0]       err_ovf,
    output logic [NUM_VC-1:0]       err_udf
`ifdef VCF_OCC_EN
    ,
    output logic [NUM_VC*CNT_W-1:0] occ
`endif
);

    logic [NUM_VC-1:0] wr_sel, rd_sel, rd_ok;
    logic [DATA_W-1:0] head [NUM_VC];
    vc_status_t        st [NUM_VC];
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_out_q, valid_out_d;

    always_comb begin
        wr_sel      = '0;
        rd_sel      = '0;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        for (int i = 0; i < NUM_VC; i++) begin
            wr_sel[i] = wr_en && (wr_vc == VC_W'(i));
            rd_sel[i] = rd_en && (rd_vc == VC_W'(i));
            if (rd_ok[i]) begin
                data_out_d  = head[i];
                valid_out_d = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
        vc_fifo_channel #(
            .DATA_W(DATA_W),
            .ADDR_W(ADDR_W),
            .CNT_W (CNT_W)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .init     (init),
            .wr_en    (wr_sel[i]),
            .rd_en    (rd_sel[i]),
            .data_in  (data_in),
            .umbral_lo(umbral_lo[i*CNT_W +: CNT_W]),
            .umbral_hi(umbral_hi[i*CNT_W +: CNT_W]),
            .head     (head[i]),
            .status   (st[i]),
            .rd_ok    (rd_ok[i]),
            .err_ovf  (err_ovf[i]),
            .err_udf  (err_udf[i])
`ifdef VCF_OCC_EN
            ,
            .cnt      (occ[i*CNT_W +: CNT_W])
`endif
        );
        assign head_data[i*DATA_W +: DATA_W] = head[i];
        assign full[i]         = st[i].full;
        assign empty[i]        = st[i].empty;
        assign almost_full[i]  = st[i].almost_full;
        assign almost_empty[i] = st[i].almost_empty;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || !init) begin
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;

endmodule

// File: tb/tb_vc_fifo_bank.sv
// tb_vc_fifo_bank: scoreboard bench for vc_fifo_bank against a queue-based channel model.
module tb_vc_fifo_bank;

    localparam int DW = 6;
    localparam int AW = 4;
    localparam int NV = 2;
    localparam int CW = 5;
    localparam int DEPTH = 16;

    logic            clk = 0, reset = 1, init = 1;
    logic            wr_en = 0, rd_en = 0;
    logic [0:0]      wr_vc = 0, rd_vc = 0;
    logic [DW-1:0]   data_in = 0;
    logic [NV*CW-1:0] umbral_lo, umbral_hi;
    logic [DW-1:0]   data_out;
    logic            valid_out;
    logic [NV*DW-1:0] head_data;
    logic [NV-1:0]   full, empty, almost_full, almost_empty, err_ovf, err_udf;
`ifdef VCF_OCC_EN
    logic [NV*CW-1:0] occ;
`endif

    vc_fifo_bank #(.DATA_W(DW), .ADDR_W(AW), .NUM_VC(NV)) dut (
        .clk(clk), .reset(reset), .init(init),
        .wr_en(wr_en), .wr_vc(wr_vc), .data_in(data_in),
        .rd_en(rd_en), .rd_vc(rd_vc),
        .umbral_lo(umbral_lo), .umbral_hi(umbral_hi),
        .data_out(data_out), .valid_out(valid_out), .head_data(head_data),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .err_ovf(err_ovf), .err_udf(err_udf)
`ifdef VCF_OCC_EN
        , .occ(occ)
`endif
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int q [NV][$];
    int exp_q [$];
    bit m_ovf [NV], m_udf [NV];
    int last_data = 0;
    bit last_valid = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int v = 0; v < NV; v++) begin
            q[v].delete();
            m_ovf[v] = 0;
            m_udf[v] = 0;
        end
        exp_q.delete();
        last_data = 0;
        last_valid = 0;
    endtask

    task automatic check_all();
        for (int v = 0; v < NV; v++) begin
            int sz, lo, hi, lim;
            sz  = q[v].size();
            lo  = int'(umbral_lo[v*CW +: CW]);
            hi  = int'(umbral_hi[v*CW +: CW]);
            lim = (hi > DEPTH) ? 0 : DEPTH - hi;
            chk($sformatf("empty[%0d]", v), int'(empty[v]), int'(sz == 0));
            chk($sformatf("full[%0d]", v), int'(full[v]), int'(sz == DEPTH));
            chk($sformatf("almost_empty[%0d]", v), int'(almost_empty[v]), int'(sz <= lo));
            chk($sformatf("almost_full[%0d]", v), int'(almost_full[v]), int'(sz >= lim && sz != DEPTH));
            chk($sformatf("err_ovf[%0d]", v), int'(err_ovf[v]), int'(m_ovf[v]));
            chk($sformatf("err_udf[%0d]", v), int'(err_udf[v]), int'(m_udf[v]));
            if (sz > 0) chk($sformatf("head_data[%0d]", v), int'(head_data[v*DW +: DW]), q[v][0]);
`ifdef VCF_OCC_EN
            chk($sformatf("occ[%0d]", v), int'(occ[v*CW +: CW]), sz);
`endif
        end
        chk("data_out", int'(data_out), last_data);
        chk("valid_out", int'(valid_out), int'(last_valid));
    endtask

    // One clock: drive request, model the edge with start-of-cycle flags, then check status.
    task automatic step(input bit w, input int wv, input int d, input bit r, input int rv);
        bit was_full, was_empty;
        wr_en = w; wr_vc = 1'(wv); data_in = DW'(d);
        rd_en = r; rd_vc = 1'(rv);
        @(posedge clk);
        was_full  = q[wv].size() == DEPTH;
        was_empty = q[rv].size() == 0;
        last_valid = 0;
        if (r) begin
            if (was_empty) m_udf[rv] = 1;
            else begin
                last_data = q[rv].pop_front();
                last_valid = 1;
                exp_q.push_back(last_data);
            end
        end
        if (w) begin
            if (was_full) m_ovf[wv] = 1;
            else q[wv].push_back(d);
        end
        #1;
        wr_en = 0; rd_en = 0;
        check_all();
    endtask

    task automatic flush();
        init = 0;
        @(posedge clk);
        model_clear();
        #1;
        init = 1;
        check_all();
    endtask

    always @(negedge clk) begin
        if (!reset && valid_out) begin
            if (exp_q.size() == 0) chk("sb_unexpected_valid", 1, 0);
            else chk("sb_data_out", int'(data_out), exp_q.pop_front());
        end
    end

    initial begin
        umbral_lo = {5'd2, 5'd2};
        umbral_hi = {5'd2, 5'd2};
        model_clear();
        #12 reset = 0;
        #1 check_all();
        chk("reset_empty", int'(empty), 3);

        for (int i = 1; i <= 16; i++) step(1, 1, i, 0, 0);
        step(1, 1, 6'h3F, 0, 0);
        chk("ovf_vc1", int'(err_ovf), 2);
        chk("full_vc1", int'(full), 2);

        for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        chk("udf_hold", int'(data_out), 16);
        chk("udf_vc1", int'(err_udf), 2);

        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 10; i++) step(1, 0, $urandom_range(0, 63), 0, 0);
            for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0);
        end

        for (int i = 0; i < 5; i++) step(1, 0, 40 + i, 0, 0);
        step(1, 0, 50, 1, 0);
        chk("simul_count5", q[0].size(), 5);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
        step(1, 0, 33, 1, 0);
        chk("simul_empty_udf", int'(err_udf[0]), 1);
        step(0, 0, 0, 1, 0);

        for (int i = 0; i < 7; i++) step(1, 1, i + 9, 0, 0);
        flush();
        chk("init_empty1", int'(empty[1]), 1);

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 40) == 0) begin
                umbral_lo = NV*CW'($urandom());
                umbral_hi = NV*CW'($urandom());
            end
            if ($urandom_range(0, 150) == 0) flush();
            else step(($urandom_range(0, 99) < 55), $urandom_range(0, 1), $urandom_range(0, 63),
                      ($urandom_range(0, 99) < 45), $urandom_range(0, 1));
        end
        for (int i = 0; i < 17; i++) step(0, 0, 0, 1, 0);
        for (int i = 0; i < 17; i++) step(0, 0, 0, 1, 1);

        step(1, 1, 21, 0, 0);
        step(0, 0, 0, 1, 1);
        chk("pre_reset_valid", int'(valid_out), 1);
        @(negedge clk);
        step(1, 0, 22, 0, 0);
        step(0, 0, 0, 1, 0);
        exp_q.delete();
        #1 reset = 1;
        #1;
        chk("async_reset_valid", int'(valid_out), 0);
        chk("async_reset_data", int'(data_out), 0);
        model_clear();
        @(negedge clk);
        #1 reset = 0;
        #1 check_all();

        @(negedge clk);
        #1 chk("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vc_fifo_bank.md
# vc_fifo_bank

Parametrised multi-virtual-channel FIFO bank for the PCIe transmit-layer datapath. It holds NUM_VC independent circular FIFOs behind one shared write port and one shared read port, each addressed by a channel index. Per-channel programmable almost-full/almost-empty thresholds and sticky overflow/underflow errors are provided. A per-channel head-of-queue peek bus feeds the downstream arbiter.

## Interface
Parameters:
- DATA_W, 6, payload width in bits
- ADDR_W, 4, per-channel depth is DEPTH = 2**ADDR_W
- NUM_VC, 2, number of virtual channels (≥1)
- VC_W, $clog2(NUM_VC) (min 1), channel-index width (derived)
- CNT_W, ADDR_W+1, occupancy width (derived, holds 0..DEPTH)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- init  in  1  active-low synchronous flush
- wr_en  in  1  write request
- wr_vc  in  VC_W  target channel of write
- data_in  in  DATA_W  write payload
- rd_en  in  1  read request
- rd_vc  in  VC_W  source channel of read
- umbral_lo  in  NUM_VC*CNT_W  per-channel almost-empty threshold, channel i at [i*CNT_W +: CNT_W]
- umbral_hi  in  NUM_VC*CNT_W  per-channel almost-full margin, same packing
- data_out  out  DATA_W  registered read data
- valid_out  out  1  data_out updated this cycle
- head_data  out  NUM_VC*DATA_W  head-of-queue word per channel (combinational from memory)
- full, empty, almost_full, almost_empty  out  NUM_VC each  per-channel status
- err_ovf, err_udf  out  NUM_VC each  sticky overflow/underflow
- occ  out  NUM_VC*CNT_W  per-channel occupancy (only with VCF_OCC_EN)

## Operation
- Reset (async) and init low (sync, priority after reset): all pointers and counts 0, data_out 0, valid_out 0, err_* 0. Memory contents are not cleared. head_data is don't-care while empty.
- Status is combinational from the count: full = (cnt==DEPTH), empty = (cnt==0), almost_empty = (cnt<=umbral_lo[i]), almost_full = (cnt>=DEPTH-umbral_hi[i]) && !full. Subtraction is done in CNT_W bits; if umbral_hi > DEPTH, it saturates to 0.
- Write: accepted when wr_en && !full[wr_vc] at the clock edge. Writes mem[wr_vc][wr_ptr], and wr_ptr increments with natural wrap at DEPTH.
- Write to a full channel: data is dropped, the pointer is unchanged, and err_ovf[wr_vc] is set.
- Read: accepted when rd_en && !empty[rd_vc]. data_out <= mem[rd_vc][rd_ptr], rd_ptr increments, valid_out = 1.
- Read from an empty channel: ignored, valid_out = 0, data_out holds, err_udf[rd_vc] is set.
- When no read is accepted, valid_out = 0 and data_out holds its last value.
- Full and empty are sampled at the start of the cycle.
  - Write and read to the same full channel in one cycle: the read is accepted and the write is rejected (overflow).
  - Write and read to the same empty channel: the write is accepted and the read is rejected (underflow).
- Count update per channel: +1 on accepted write only, -1 on accepted read only, unchanged on both or neither. Counts never leave 0..DEPTH.
- err_* bits clear only on reset or on init low.

## Timing
- Read latency: 1 cycle from the accepting edge to data_out/valid_out.
- Write-to-visibility: a word written at edge N appears in head_data and in status from edge N onward (after the edge). The earliest it can be read is with rd_en asserted in the cycle after N.
- head_data[i] reflects mem[i][rd_ptr[i]] combinationally. It updates the cycle after a pop.
- Reset assertion mid-transfer aborts the in-flight read. valid_out drops asynchronously.

## Configuration
- VCF_OCC_EN defined: the occ port exists and is driven with the live per-channel count.
- VCF_OCC_EN undefined: the occ port is absent. No other behaviour changes.

## Structure
- Package vc_fifo_pkg holds:
  - a function clog2_min1 for VC_W
  - a localparam helper for CNT_W
  - a typedef for the per-channel status struct {full, empty, almost_full, almost_empty}
- Sub-module vc_fifo_channel: one circular FIFO with its pointers, count, flags and sticky errors. It is instantiated NUM_VC times under a generate loop.
- The top level holds wr_vc/rd_vc decode, the shared data_out/valid_out register, and output packing.

## Test plan
- Reset, then init=1 with NUM_VC=2, DEPTH=16, umbral_lo=2, umbral_hi=2 -> empty=2'b11, full=0, almost_empty=2'b11, err=0, data_out=0.
- Write 16 words 0x01..0x10 to VC1, then one more word 0x3F -> full[1]=1 at count 16; 0x3F dropped; err_ovf[1]=1; VC0 unaffected; almost_full[1] asserted at counts 14–15.
- Read all 16 words from VC1 -> data_out = 0x01..0x10 in order, each one cycle after rd_en, with valid_out each cycle. A 17th read gives valid_out=0, data_out holds 0x10, err_udf[1]=1.
- Wrap-around: fill and drain VC0 in 10-word bursts, three times -> order preserved across the pointer wrap, and head_data[0] always equals the next data_out.
- Simultaneous write and read on VC0 at count 5 -> count stays 5 and the oldest word is output. Same on an empty VC0 -> write taken, valid_out=0, err_udf[0]=1.
- Pulse init low for one cycle with 7 words in VC1 -> count 0, err cleared, empty[1]=1. Assert reset asynchronously mid-read -> valid_out=0 immediately.
